// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache-to-AXI block transfer controller and its arbiter.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    GAP,
    REFILL,
    DONE
  } state_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_t;

  // Byte-offset bits within one cache line.
  function automatic int offs_bits(input int block_width);
    return $clog2(block_width / 8);
  endfunction

endpackage

// File: rtl/cache_transfer_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant updated on i_update.
// Latency 0 (grant valid same cycle as requests); no backpressure, caller decides when to commit.
module rr_arbiter2
  import cache_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output req_id_t    o_gnt
);

  req_id_t last_q;

  always_comb begin
    o_gnt = REQ_ICACHE;
    if (i_req == 2'b11) begin
      if (last_q == REQ_ICACHE) o_gnt = REQ_DCACHE;
      else                      o_gnt = REQ_ICACHE;
    end else if (i_req[1]) begin
      o_gnt = REQ_DCACHE;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)     last_q <= REQ_ICACHE;
    else if (i_update) last_q <= o_gnt;
  end

endmodule

// File: rtl/cache_transfer_ctrl.sv
// Owns the shared cache<->AXI block datapath: arbitrates I/D line requests, sequences writeback -> gap -> refill.
// Grant 1 cycle after request seen; done pulses 1 cycle after final beat; requests held by caches until done.
module cache_transfer_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic                      i_icache_req,
  input  logic [AXI_ADDR_WIDTH-1:0] i_icache_addr,
  input  logic                      i_dcache_req,
  input  logic                      i_dcache_dirty,
  input  logic [AXI_ADDR_WIDTH-1:0] i_dcache_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] i_dcache_wb_addr,
  input  logic                      i_count_done,
  output logic                      o_start_read,
  output logic                      o_start_write,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr_cache,
  output logic                      o_icache_done,
  output logic                      o_dcache_done,
  output logic                      o_grant_dcache,
  output logic                      o_busy
);

  localparam int OFFS = offs_bits(BLOCK_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = {AXI_ADDR_WIDTH{1'b1}} << OFFS;

  state_t                    state_q, state_d;
  req_id_t                   owner_q;
  logic [AXI_ADDR_WIDTH-1:0] refill_addr_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;

  logic                      any_req;
  req_id_t                   arb_gnt;
  logic                      wb_first;
  logic [AXI_ADDR_WIDTH-1:0] grant_refill;
  logic [AXI_ADDR_WIDTH-1:0] grant_wb;

  assign any_req = i_icache_req | i_dcache_req;

  rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_req    ({i_dcache_req, i_icache_req}),
    .i_update ((state_q == IDLE) && any_req),
    .o_gnt    (arb_gnt)
  );

  assign wb_first     = (arb_gnt == REQ_DCACHE) && i_dcache_dirty;
  assign grant_refill = ((arb_gnt == REQ_DCACHE) ? i_dcache_addr : i_icache_addr) & LINE_MASK;
  assign grant_wb     = i_dcache_wb_addr & LINE_MASK;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (any_req) state_d = wb_first ? WRITEBACK : REFILL;
      WRITEBACK: if (i_count_done) state_d = GAP;
      GAP:       state_d = REFILL;
      REFILL:    if (i_count_done) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The writeback address is only needed during WRITEBACK, so it lives in addr_q alone.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q       <= IDLE;
      owner_q       <= REQ_ICACHE;
      refill_addr_q <= '0;
      addr_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q       <= arb_gnt;
            refill_addr_q <= grant_refill;
            addr_q        <= wb_first ? grant_wb : grant_refill;
          end
        end
        WRITEBACK: if (i_count_done) addr_q <= refill_addr_q;
        DONE:      addr_q <= '0;
        default:   ;
      endcase
    end
  end

  assign o_start_write  = (state_q == WRITEBACK);
  assign o_start_read   = (state_q == REFILL);
  assign o_addr_cache   = addr_q;
  assign o_busy         = (state_q != IDLE);
  assign o_grant_dcache = o_busy && (owner_q == REQ_DCACHE);
  assign o_icache_done  = (state_q == DONE) && (owner_q == REQ_ICACHE);
  assign o_dcache_done  = (state_q == DONE) && (owner_q == REQ_DCACHE);

endmodule

// File: tb/tb_cache_transfer_ctrl.sv
// Bench for cache_transfer_ctrl: directed vector table, hand sequences, and randomized traffic against a transaction model.
module tb_cache_transfer_ctrl;

  localparam int AW = 64;
  localparam logic [AW-1:0] LMASK = ~(AW'(63));

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          ireq = 1'b0, dreq = 1'b0, dirty = 1'b0, cd = 1'b0;
  logic [AW-1:0] iaddr = '0, daddr = '0, wbaddr = '0;
  logic          start_read, start_write, icache_done, dcache_done, grant_dcache, busy;
  logic [AW-1:0] addr_cache;

  cache_transfer_ctrl #(.AXI_ADDR_WIDTH(AW), .BLOCK_WIDTH(512)) dut (
    .i_clk            (clk),
    .i_arst_n         (arst_n),
    .i_icache_req     (ireq),
    .i_icache_addr    (iaddr),
    .i_dcache_req     (dreq),
    .i_dcache_dirty   (dirty),
    .i_dcache_addr    (daddr),
    .i_dcache_wb_addr (wbaddr),
    .i_count_done     (cd),
    .o_start_read     (start_read),
    .o_start_write    (start_write),
    .o_addr_cache     (addr_cache),
    .o_icache_done    (icache_done),
    .o_dcache_done    (dcache_done),
    .o_grant_dcache   (grant_dcache),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          idone;
    logic          ddone;
    logic          gd;
    logic          busy;
    logic [AW-1:0] addr;
  } out_t;

  typedef struct {
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          dreq;
    logic          dirty;
    logic [AW-1:0] daddr;
    logic [AW-1:0] wbaddr;
    logic          cd;
    out_t          exp;
    bit            chk_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic out_t o(input logic rd, wr, id, dd, gd, bz, input logic [AW-1:0] a);
    out_t r;
    r.rd = rd; r.wr = wr; r.idone = id; r.ddone = dd; r.gd = gd; r.busy = bz; r.addr = a;
    return r;
  endfunction

  function automatic vec_t mk(input logic ir, input logic [AW-1:0] ia, input logic dr, dt,
                              input logic [AW-1:0] da, wa, input logic c, input out_t e, input bit ca);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dirty = dt; v.daddr = da; v.wbaddr = wa;
    v.cd = c; v.exp = e; v.chk_addr = ca;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t exp, input bit chk_addr);
    out_t act;
    act = o(start_read, start_write, icache_done, dcache_done, grant_dcache, busy, addr_cache);
    if (!chk_addr) begin
      act.addr = '0;
      exp.addr = '0;
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rd=%0b wr=%0b idone=%0b ddone=%0b gd=%0b busy=%0b addr=%h, want rd=%0b wr=%0b idone=%0b ddone=%0b gd=%0b busy=%0b addr=%h",
               name, act.rd, act.wr, act.idone, act.ddone, act.gd, act.busy, act.addr,
               exp.rd, exp.wr, exp.idone, exp.ddone, exp.gd, exp.busy, exp.addr);
    end
  endtask

  task automatic do_reset();
    ireq = 0; dreq = 0; dirty = 0; cd = 0;
    @(negedge clk);
    arst_n = 1'b0;
    #2;
    check("reset", o(0, 0, 0, 0, 0, 0, '0), 1);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Transaction model: a grant plans the remaining phases as a queue.
  typedef enum {SEG_WB, SEG_GAP, SEG_RD, SEG_DONE} seg_e;
  seg_e          segs[$];
  int            m_last;
  int            m_owner;
  logic [AW-1:0] m_refill, m_wb;

  task automatic model_reset();
    segs.delete();
    m_last = 0;
    m_owner = 0;
  endtask

  task automatic model_step(output out_t e, output bit ca);
    if (segs.size() == 0) begin
      if (ireq || dreq) begin
        if (ireq && dreq) m_owner = 1 - m_last;
        else              m_owner = dreq ? 1 : 0;
        m_last = m_owner;
        if (m_owner == 1) begin
          m_refill = daddr & LMASK;
          m_wb = wbaddr & LMASK;
          if (dirty) segs = {SEG_WB, SEG_GAP, SEG_RD, SEG_DONE};
          else       segs = {SEG_RD, SEG_DONE};
        end else begin
          m_refill = iaddr & LMASK;
          segs = {SEG_RD, SEG_DONE};
        end
      end
    end else if (segs[0] == SEG_GAP || segs[0] == SEG_DONE || cd) begin
      void'(segs.pop_front());
    end
    e = '0;
    ca = 0;
    if (segs.size() != 0) begin
      e.busy = 1;
      e.gd = (m_owner == 1);
      case (segs[0])
        SEG_WB:   begin e.wr = 1; e.addr = m_wb; ca = 1; end
        SEG_GAP:  begin e.addr = m_refill; ca = 1; end
        SEG_RD:   begin e.rd = 1; e.addr = m_refill; ca = 1; end
        SEG_DONE: begin e.idone = (m_owner == 0); e.ddone = (m_owner == 1); end
        default:  ;
      endcase
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[19];
    int   order[$];
    int   want_order[4];
    out_t e;
    bit   ca;
    logic [AW-1:0] ia;

    ia = 64'h8000_0044;
    // I-only refill, spurious count_done in IDLE
    tbl[0]  = mk(1, ia, 0, 0, '0, '0, 0, o(1, 0, 0, 0, 0, 1, 64'h8000_0040), 1);
    tbl[1]  = mk(1, ia, 0, 0, '0, '0, 0, o(1, 0, 0, 0, 0, 1, 64'h8000_0040), 1);
    tbl[2]  = mk(1, ia, 0, 0, '0, '0, 1, o(0, 0, 1, 0, 0, 1, '0), 0);
    tbl[3]  = mk(0, ia, 0, 0, '0, '0, 0, o(0, 0, 0, 0, 0, 0, '0), 0);
    tbl[4]  = mk(0, ia, 0, 0, '0, '0, 1, o(0, 0, 0, 0, 0, 0, '0), 0);
    // D dirty: writeback, single gap (count_done there ignored), refill
    tbl[5]  = mk(0, '0, 1, 1, 64'h2000, 64'h1000, 0, o(0, 1, 0, 0, 1, 1, 64'h1000), 1);
    tbl[6]  = mk(0, '0, 1, 1, 64'h2000, 64'h1000, 0, o(0, 1, 0, 0, 1, 1, 64'h1000), 1);
    tbl[7]  = mk(0, '0, 1, 1, 64'h2000, 64'h1000, 1, o(0, 0, 0, 0, 1, 1, 64'h2000), 1);
    tbl[8]  = mk(0, '0, 1, 1, 64'h2000, 64'h1000, 1, o(1, 0, 0, 0, 1, 1, 64'h2000), 1);
    tbl[9]  = mk(0, '0, 1, 1, 64'h2000, 64'h1000, 0, o(1, 0, 0, 0, 1, 1, 64'h2000), 1);
    tbl[10] = mk(0, '0, 1, 1, 64'h2000, 64'h1000, 1, o(0, 0, 0, 1, 1, 1, '0), 0);
    tbl[11] = mk(0, '0, 0, 0, 64'h2000, 64'h1000, 0, o(0, 0, 0, 0, 0, 0, '0), 0);
    // D clean goes straight to refill
    tbl[12] = mk(0, '0, 1, 0, 64'h3000_007F, 64'h1000, 0, o(1, 0, 0, 0, 1, 1, 64'h3000_0040), 1);
    tbl[13] = mk(0, '0, 1, 0, 64'h3000_007F, 64'h1000, 1, o(0, 0, 0, 1, 1, 1, '0), 0);
    tbl[14] = mk(0, '0, 0, 0, 64'h3000_007F, 64'h1000, 0, o(0, 0, 0, 0, 0, 0, '0), 0);
    // requester drops and changes address mid-refill
    tbl[15] = mk(1, 64'h1234, 0, 0, '0, '0, 0, o(1, 0, 0, 0, 0, 1, 64'h1200), 1);
    tbl[16] = mk(0, 64'hFFFF_FFC0, 1, 1, 64'h5000, 64'h6000, 0, o(1, 0, 0, 0, 0, 1, 64'h1200), 1);
    tbl[17] = mk(0, 64'hFFFF_FFC0, 0, 0, 64'h5000, 64'h6000, 1, o(0, 0, 1, 0, 0, 1, '0), 0);
    tbl[18] = mk(0, 64'hFFFF_FFC0, 0, 0, 64'h5000, 64'h6000, 0, o(0, 0, 0, 0, 0, 0, '0), 0);

    do_reset();
    #1;
    for (int i = 0; i < 19; i++) begin
      ireq = tbl[i].ireq; iaddr = tbl[i].iaddr; dreq = tbl[i].dreq; dirty = tbl[i].dirty;
      daddr = tbl[i].daddr; wbaddr = tbl[i].wbaddr; cd = tbl[i].cd;
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].chk_addr);
    end

    // Both held after reset: D first, then alternation
    do_reset();
    #1;
    ireq = 1; dreq = 1; dirty = 0; cd = 1;
    iaddr = 64'h100; daddr = 64'h200;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      tick();
      if (icache_done) order.push_back(0);
      if (dcache_done) order.push_back(1);
    end
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, want 4", order.size());
    end
    want_order = '{1, 0, 1, 0};
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      checks++;
      if (order[k] != want_order[k]) begin
        errors++;
        $display("FAIL rr_order%0d: got owner %0d, want %0d", k, order[k], want_order[k]);
      end
    end
    ireq = 0; dreq = 0; cd = 0;

    // Reset asserted mid-refill, then clean re-grant
    do_reset();
    #1;
    ireq = 1; iaddr = 64'h4000_0008; cd = 0;
    tick();
    check("rst_pre", o(1, 0, 0, 0, 0, 1, 64'h4000_0000), 1);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("rst_mid", o(0, 0, 0, 0, 0, 0, '0), 1);
    #2;
    arst_n = 1'b1;
    tick();
    check("rst_regrant", o(1, 0, 0, 0, 0, 1, 64'h4000_0000), 1);
    cd = 1;
    tick();
    check("rst_done", o(0, 0, 1, 0, 0, 1, '0), 0);
    ireq = 0; cd = 0;
    tick();
    check("rst_idle", o(0, 0, 0, 0, 0, 0, '0), 0);

    // Randomized traffic against the transaction model
    do_reset();
    model_reset();
    #1;
    for (int c = 0; c < 3000; c++) begin
      ireq = ($urandom_range(0, 9) < 4);
      dreq = ($urandom_range(0, 9) < 4);
      dirty = $urandom_range(0, 1) == 1;
      cd = ($urandom_range(0, 3) == 0);
      iaddr = {$urandom, $urandom};
      daddr = {$urandom, $urandom};
      wbaddr = {$urandom, $urandom};
      model_step(e, ca);
      tick();
      check($sformatf("rand%0d", c), e, ca);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
